// File: rtl/fifo_pkg.sv
// Shared types for the SRAM FIFO read-side stream adapter.
package fifo_pkg;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

   // Number of words the read-side skid buffer can hold.
   localparam int RDR_DEPTH = 2;

endpackage

// File: rtl/fifo_rdr_skid.sv
// Two-entry register skid buffer. Entry 0 is the stream head and drives
// out_data. Words leave in strict arrival order.
module fifo_rdr_skid
   import fifo_pkg::*;
#(
   parameter int WIDTH = 128
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occ
);

   occ_e             occ_q, occ_d;
   logic [WIDTH-1:0] ent0_q, ent0_d;
   logic [WIDTH-1:0] ent1_q, ent1_d;
   logic             pop;

   assign pop      = out_valid & out_ready;
   assign out_data = ent0_q;
   assign occ      = occ_q;

   // Next occupancy and entry contents from push/pop.
   always_comb begin
      occ_d  = occ_q;
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      case (occ_q)
         OCC_EMPTY: begin
            if (push) begin
               occ_d  = OCC_ONE;
               ent0_d = push_data;
            end
         end
         OCC_ONE: begin
            if (push && pop) begin
               ent0_d = push_data;
            end else if (push) begin
               occ_d  = OCC_TWO;
               ent1_d = push_data;
            end else if (pop) begin
               occ_d  = OCC_EMPTY;
            end
         end
         OCC_TWO: begin
            if (pop) begin
               ent0_d = ent1_q;
               // A prefetching FIFO can refill in the same cycle a word leaves.
               if (push) ent1_d = push_data;
               else      occ_d  = OCC_ONE;
            end
         end
         default: occ_d = OCC_EMPTY;
      endcase
   end

   // State and entry registers; out_valid is registered from next occupancy.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         occ_q     <= OCC_EMPTY;
         ent0_q    <= '0;
         ent1_q    <= '0;
         out_valid <= 1'b0;
      end else begin
         occ_q     <= occ_d;
         ent0_q    <= ent0_d;
         ent1_q    <= ent1_d;
         out_valid <= (occ_d != OCC_EMPTY);
      end
   end

endmodule

// File: rtl/fifo_stream_rdr.sv
// Drains a dual-port SRAM FIFO read port and presents the words as a
// valid/ready stream. Credit logic keeps at most two words buffered or in
// flight so the skid buffer never overflows.
// Optional: define FIFO_RDR_STATS_EN to add the rd_beats delivered-word counter.
module fifo_stream_rdr #(
   parameter int WIDTH      = 128,
   parameter int RD_LATENCY = 1
) (
   input  logic             clk,
   input  logic             rstb,
   output logic             fifo_rd_en,
   input  logic             fifo_rd_empty,
   input  logic [WIDTH-1:0] fifo_rd_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef FIFO_RDR_STATS_EN
   ,
   output logic [31:0]      rd_beats
`endif
);
   import fifo_pkg::*;

   if (RD_LATENCY != 0 && RD_LATENCY != 1) begin : g_bad_lat
      $error("fifo_stream_rdr: RD_LATENCY must be 0 or 1, got %0d", RD_LATENCY);
   end

   logic              push;
   logic              pop;
   logic              inflight;
   logic [1:0]        occ;
   logic signed [2:0] credit;

   assign pop = out_valid & out_ready;

   // A pop this cycle frees a slot that a same-cycle read may claim.
   assign credit = signed'(3'(RDR_DEPTH)) - signed'({1'b0, occ})
                 - signed'({2'b0, inflight}) + signed'({2'b0, pop});

   assign fifo_rd_en = rstb & ~fifo_rd_empty & (credit > 3'sd0);

   if (RD_LATENCY == 0) begin : g_lat0
      assign inflight = 1'b0;
      assign push     = fifo_rd_en;
   end else begin : g_lat1
      logic inflight_q;
      // One read outstanding; its data lands in the following cycle.
      always_ff @(posedge clk) begin
         if (!rstb) inflight_q <= 1'b0;
         else       inflight_q <= fifo_rd_en;
      end
      assign inflight = inflight_q;
      assign push     = inflight_q;
   end

   fifo_rdr_skid #(.WIDTH(WIDTH)) u_skid (
      .clk       (clk),
      .rstb      (rstb),
      .push      (push),
      .push_data (fifo_rd_data),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .occ       (occ)
   );

`ifdef FIFO_RDR_STATS_EN
   logic [31:0] beats_q;
   // Count delivered words; wraps naturally at 32 bits.
   always_ff @(posedge clk) begin
      if (!rstb)    beats_q <= '0;
      else if (pop) beats_q <= beats_q + 32'd1;
   end
   assign rd_beats = beats_q;
`endif

   // Credit accounting must keep the buffer from being pushed while full.
   a_no_overrun: assert property (@(posedge clk) disable iff (!rstb)
      !(push && (occ == OCC_TWO) && !pop))
      else $error("fifo_stream_rdr: push into full skid buffer");

   // The FIFO must never be popped while it reports empty.
   a_no_pop_empty: assert property (@(posedge clk) disable iff (!rstb)
      !(fifo_rd_en && fifo_rd_empty))
      else $error("fifo_stream_rdr: rd_en while FIFO empty");

endmodule
